// File: rtl/ram_rd_arbiter_pkg.sv
// Shared constants and helpers for the RAM read arbiter.
// Index width helper keeps per-requester pointers compact.
package ram_arb_pkg;

  localparam int STATS_CNT_W = 16;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ram_rd_arbiter_rr_pick.sv
// Round-robin picker: first active request at or above ptr,
// wrapping modulo N. Purely combinational.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);

  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found   = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IW'(j);
      end
    end
  end

  assign gnt_any = |req;

endmodule

// File: rtl/ram_rd_arbiter.sv
// Round-robin read arbiter in front of a single-port RAM.
// Optional per-requester stats under RAM_RD_ARBITER_STATS_EN.
module ram_rd_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ_P = 4,
  parameter int ADDR_W_P  = 8,
  parameter int DATA_W_P  = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
`ifdef RAM_RD_ARBITER_STATS_EN
  output logic [NUM_REQ_P*STATS_CNT_W-1:0] grant_cnt,
`endif
  input  logic [NUM_REQ_P-1:0]          req_val,
  input  logic [NUM_REQ_P*ADDR_W_P-1:0] req_addr,
  output logic [NUM_REQ_P-1:0]          req_rdy,
  output logic [NUM_REQ_P-1:0]          resp_val,
  output logic [ADDR_W_P-1:0]           resp_addr,
  output logic [DATA_W_P-1:0]           resp_data,
  input  logic [NUM_REQ_P-1:0]          resp_rdy,
  output logic                          mem_rd_req_val,
  output logic [ADDR_W_P-1:0]           mem_rd_req_addr,
  input  logic                          mem_rd_req_rdy,
  input  logic                          mem_rd_resp_val,
  input  logic [ADDR_W_P-1:0]           mem_rd_resp_addr,
  input  logic [DATA_W_P-1:0]           mem_rd_resp_data,
  output logic                          mem_rd_resp_rdy
);

  localparam int IW = idx_w(NUM_REQ_P);
  localparam logic [IW-1:0] LAST = IW'(NUM_REQ_P - 1);

  logic [IW-1:0]        ptr;
  logic [IW-1:0]        owner;
  logic [IW-1:0]        ptr_nxt;
  logic [NUM_REQ_P-1:0] gnt;
  logic [IW-1:0]        gnt_idx;
  logic                 gnt_any;
  logic                 hs;
  logic [ADDR_W_P-1:0]  addr_a [NUM_REQ_P];

  rr_pick #(
    .N  (NUM_REQ_P),
    .IW (IW)
  ) u_pick (
    .req     (req_val),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  for (genvar i = 0; i < NUM_REQ_P; i++) begin : g_addr
    assign addr_a[i] = req_addr[i*ADDR_W_P +: ADDR_W_P];
  end

  assign mem_rd_req_val  = gnt_any;
  assign mem_rd_req_addr = addr_a[gnt_idx];
  assign req_rdy         = gnt & {NUM_REQ_P{mem_rd_req_rdy}};
  assign hs              = mem_rd_req_val & mem_rd_req_rdy;
  assign ptr_nxt = (gnt_idx == LAST) ? '0 : gnt_idx + IW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr   <= '0;
      owner <= '0;
    end else if (hs) begin
      ptr   <= ptr_nxt;
      owner <= gnt_idx;
    end
  end

  // Response side is steered purely by the registered owner.
  always_comb begin
    resp_val        = '0;
    resp_val[owner] = mem_rd_resp_val;
  end

  assign mem_rd_resp_rdy = resp_rdy[owner];
  assign resp_addr       = mem_rd_resp_addr;
  assign resp_data       = mem_rd_resp_data;

`ifdef RAM_RD_ARBITER_STATS_EN
  for (genvar i = 0; i < NUM_REQ_P; i++) begin : g_cnt
    logic [STATS_CNT_W-1:0] cnt;
    always_ff @(posedge clk) begin
      if (!rst_n)
        cnt <= '0;
      else if (hs && gnt[i] && (cnt != '1))
        cnt <= cnt + STATS_CNT_W'(1);
    end
    assign grant_cnt[i*STATS_CNT_W +: STATS_CNT_W] = cnt;
  end
`endif

endmodule

// File: tb/tb_ram_rd_arbiter.sv
// Randomized bench for ram_rd_arbiter with a RAM stand-in and
// a request-level reference model; define RAM_RD_ARBITER_STATS_EN for stats.
module tb_ram_rd_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_val;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]  req_rdy;
  logic [N-1:0]  resp_val;
  logic [AW-1:0] resp_addr;
  logic [DW-1:0] resp_data;
  logic [N-1:0]  resp_rdy;
  logic          mem_rd_req_val;
  logic [AW-1:0] mem_rd_req_addr;
  logic          mem_rd_req_rdy;
  logic          mem_rd_resp_val;
  logic [AW-1:0] mem_rd_resp_addr;
  logic [DW-1:0] mem_rd_resp_data;
  logic          mem_rd_resp_rdy;
`ifdef RAM_RD_ARBITER_STATS_EN
  logic [N*16-1:0] grant_cnt;
`endif

  // RAM stand-in: one response register, stalls while it is held
  logic          ram_v;
  logic [AW-1:0] ram_a;
  logic [DW-1:0] ram_d;
  logic          ram_stall;

  int mptr;
  int mown;
  int mcnt [N];
  int vecs;
  int errs;

  assign mem_rd_req_rdy   = !ram_stall && (!ram_v || mem_rd_resp_rdy);
  assign mem_rd_resp_val  = ram_v;
  assign mem_rd_resp_addr = ram_a;
  assign mem_rd_resp_data = ram_d;

  ram_rd_arbiter #(
    .NUM_REQ_P (N),
    .ADDR_W_P  (AW),
    .DATA_W_P  (DW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
`ifdef RAM_RD_ARBITER_STATS_EN
    .grant_cnt        (grant_cnt),
`endif
    .req_val          (req_val),
    .req_addr         (req_addr),
    .req_rdy          (req_rdy),
    .resp_val         (resp_val),
    .resp_addr        (resp_addr),
    .resp_data        (resp_data),
    .resp_rdy         (resp_rdy),
    .mem_rd_req_val   (mem_rd_req_val),
    .mem_rd_req_addr  (mem_rd_req_addr),
    .mem_rd_req_rdy   (mem_rd_req_rdy),
    .mem_rd_resp_val  (mem_rd_resp_val),
    .mem_rd_resp_addr (mem_rd_resp_addr),
    .mem_rd_resp_data (mem_rd_resp_data),
    .mem_rd_resp_rdy  (mem_rd_resp_rdy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
    return 64'h0123_4567_89AB_CD00 | {56'h0, a};
  endfunction

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask

  // One clock: compare against the model, then advance model and RAM.
  task automatic cycle();
    int g;
    logic rdy;
    logic hs;
    logic [N-1:0] er;
    logic [AW-1:0] ga;
    #1;
    g = -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (mptr + k) % N;
      if (g < 0 && req_val[j]) g = j;
    end
    rdy = !ram_stall && (!ram_v || resp_rdy[mown]);
    hs  = (g >= 0) && rdy;
    er  = hs ? N'(1 << g) : '0;
    ga  = (g >= 0) ? req_addr[g*AW +: AW] : '0;
    chk("mem_req_val", 64'(mem_rd_req_val), 64'(g >= 0));
    if (g >= 0) chk("mem_req_addr", 64'(mem_rd_req_addr), 64'(ga));
    chk("req_rdy", 64'(req_rdy), 64'(er));
    chk("resp_val", 64'(resp_val), ram_v ? 64'(1 << mown) : 64'h0);
    chk("mem_resp_rdy", 64'(mem_rd_resp_rdy), 64'(resp_rdy[mown]));
    chk("resp_addr", 64'(resp_addr), 64'(ram_a));
    chk("resp_data", resp_data, ram_d);
`ifdef RAM_RD_ARBITER_STATS_EN
    for (int i = 0; i < N; i++)
      chk($sformatf("grant_cnt%0d", i),
          64'(grant_cnt[i*16 +: 16]), 64'(mcnt[i]));
`endif
    @(posedge clk);
    #1;
    if (!rst_n) begin
      mptr  = 0;
      mown  = 0;
      ram_v = 1'b0;
      for (int i = 0; i < N; i++) mcnt[i] = 0;
    end else if (hs) begin
      ram_v = 1'b1;
      ram_a = ga;
      ram_d = ram_word(ga);
      mown  = g;
      mptr  = (g + 1) % N;
      if (mcnt[g] < 65535) mcnt[g]++;
    end else if (ram_v && resp_rdy[mown]) begin
      ram_v = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [N-1:0] seq [5];
    logic [N-1:0] prev;
    vecs = 0;
    errs = 0;
    mptr = 0;
    mown = 0;
    for (int i = 0; i < N; i++) mcnt[i] = 0;
    ram_v = 1'b0;
    ram_a = '0;
    ram_d = '0;
    ram_stall = 1'b0;
    rst_n = 1'b0;
    req_val = '0;
    req_addr = '0;
    resp_rdy = '0;
    @(negedge clk);
    cycle();
    cycle();
    rst_n = 1'b1;
    #1;
    chk("idle_req_rdy", 64'(req_rdy), 64'h0);
    chk("idle_resp_val", 64'(resp_val), 64'h0);
    chk("idle_mem_val", 64'(mem_rd_req_val), 64'h0);
    cycle();

    // single requester 2 at 0x10
    req_val  = 4'b0100;
    req_addr = 32'h0010_0000;
    resp_rdy = 4'hF;
    #1;
    chk("single_req_rdy", 64'(req_rdy), 64'h4);
    cycle();
    req_val = '0;
    #1;
    chk("single_resp_val", 64'(resp_val), 64'h4);
    chk("single_resp_data", resp_data, 64'h0123_4567_89AB_CD10);
    chk("single_model_ptr", 64'(mptr), 64'd3);
    cycle();
    req_val = 4'hF;
    req_addr = 32'h4433_2211;
    #1;
    chk("after_ptr3_rdy", 64'(req_rdy), 64'h8);
    cycle();

    // all four continuous: 0,1,2,3,0
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100;
    seq[3] = 4'b1000; seq[4] = 4'b0001;
    prev = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("rr_rdy%0d", i), 64'(req_rdy), 64'(seq[i]));
      chk($sformatf("rr_resp%0d", i), 64'(resp_val), 64'(prev));
      prev = seq[i];
      cycle();
    end

    // owner 1 backpressured while 0 and 3 request
    rst_n = 1'b0;
    req_val = '0;
    cycle();
    rst_n = 1'b1;
    req_val = 4'b0010;
    cycle();
    resp_rdy = 4'b1101;
    req_val  = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp_rdy%0d", i), 64'(req_rdy), 64'h0);
      chk($sformatf("bp_resp%0d", i), 64'(resp_val), 64'h2);
      cycle();
    end
    chk("bp_model_ptr", 64'(mptr), 64'd2);
    resp_rdy = 4'hF;
    #1;
    chk("bp_release_rdy", 64'(req_rdy), 64'h8);
    cycle();

    // reset during a backpressured response
    resp_rdy = '0;
    req_val  = 4'b0110;
    cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    #1;
    chk("rst_resp_val", 64'(resp_val), 64'h0);
    chk("rst_first_gnt", 64'(req_rdy), 64'h2);
    cycle();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      req_val   = N'($urandom);
      req_addr  = $urandom;
      resp_rdy  = N'($urandom);
      ram_stall = ($urandom_range(0, 3) == 0);
      rst_n     = ($urandom_range(0, 99) != 0);
      cycle();
    end
    rst_n = 1'b1;
    ram_stall = 1'b0;

`ifdef RAM_RD_ARBITER_STATS_EN
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    req_val  = 4'b0001;
    resp_rdy = 4'hF;
    for (int n = 0; n < 70000; n++) cycle();
    req_val = '0;
    #1;
    chk("cnt_saturated", 64'(grant_cnt), 64'h0000_0000_0000_FFFF);
    cycle();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/ram_rd_arbiter.md
RAM_RD_ARBITER -- requirements
Module: ram_rd_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ_P, default 4: number of requesters, 2..8.
REQ-002 SHALL have parameter ADDR_W_P, default 8: RAM address width.
REQ-003 SHALL have parameter DATA_W_P, default 64: RAM data width.
REQ-004 One clock; reset is synchronous and active-low. Ports: clk, input, 1, rising-edge clock; rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port req_val, input, NUM_REQ_P: per-requester read request valid.
REQ-006 SHALL have port req_addr, input, NUM_REQ_P*ADDR_W_P: per-requester address; requester i occupies slice i.
REQ-007 SHALL have port req_rdy, output, NUM_REQ_P: per-requester request accept.
REQ-008 SHALL have port resp_val, output, NUM_REQ_P: per-requester response valid.
REQ-009 SHALL have port resp_addr, output, ADDR_W_P: response address, shared and broadcast.
REQ-010 SHALL have port resp_data, output, DATA_W_P: response data, shared and broadcast.
REQ-011 SHALL have port resp_rdy, input, NUM_REQ_P: per-requester response accept.
REQ-012 SHALL have port mem_rd_req_val, output, 1, together with mem_rd_req_addr, output, ADDR_W_P, and mem_rd_req_rdy, input, 1: RAM read-request port.
REQ-013 SHALL have port mem_rd_resp_val, input, 1, with mem_rd_resp_addr, input, ADDR_W_P, mem_rd_resp_data, input, DATA_W_P, and mem_rd_resp_rdy, output, 1: RAM read-response port.

Function
REQ-014 Arbitration SHALL be round-robin: priority starts at pointer ptr and ascends modulo NUM_REQ_P; the first asserted req_val wins (grant, one-hot or zero).
REQ-015 mem_rd_req_val SHALL equal OR of req_val; mem_rd_req_addr SHALL equal the granted requester's address (don't-care when no grant).
REQ-016 req_rdy[i] SHALL equal grant[i] AND mem_rd_req_rdy; all other bits 0.
REQ-017 On a handshake (mem_rd_req_val AND mem_rd_req_rdy), ptr SHALL become (granted index + 1) mod NUM_REQ_P next cycle; otherwise ptr SHALL hold.
REQ-018 On a handshake, the owner register SHALL capture the granted index; otherwise it SHALL hold.
REQ-019 resp_val[owner] SHALL equal mem_rd_resp_val; all other resp_val bits 0.
REQ-020 mem_rd_resp_rdy SHALL equal resp_rdy[owner]; resp_rdy of non-owners SHALL be ignored.
REQ-021 resp_addr and resp_data SHALL pass through from mem_rd_resp_addr and mem_rd_resp_data combinationally, with zero added latency.
REQ-022 While the RAM response is backpressured (mem_rd_req_rdy=0), the grant MAY change, but no req_rdy SHALL assert, ptr SHALL hold and owner SHALL hold.
REQ-023 Back-to-back handshakes every cycle SHALL be supported; the owner updates in the same cycle the RAM response register reloads.
REQ-024 A requester SHALL NOT be granted twice while another requester with req_val held continuously is skipped; worst-case wait is NUM_REQ_P-1 grants.

Reset
REQ-025 While rst_n=0: ptr=0, owner=0, all statistics counters=0.
REQ-026 After reset all outputs SHALL follow from register state plus inputs. With idle inputs: req_rdy=0, resp_val=0, mem_rd_req_val=0.
REQ-027 Reset asserted mid-transfer SHALL drop ownership; the RAM is reset on the same rst_n (inverted), so no stale response survives.

Configuration
REQ-028 Macro RAM_RD_ARBITER_STATS_EN: when defined, the block SHALL add output grant_cnt, NUM_REQ_P*16, holding per-requester 16-bit saturating handshake counters. Each counter increments on its requester's handshake and sticks at 0xFFFF.
REQ-029 When RAM_RD_ARBITER_STATS_EN is undefined, grant_cnt and its counters SHALL be absent, and behaviour SHALL otherwise be identical.

Structure
REQ-030 Package ram_arb_pkg SHALL hold STATS_CNT_W=16 and a function returning the index width, clog2(NUM_REQ_P).
REQ-031 A single combinational sub-module, rr_pick, SHALL compute the grant one-hot and grant index from req_val and ptr. All state SHALL reside in ram_rd_arbiter.

Verification
REQ-032 Only requester 2 requests addr 0x10 with RAM ready: req_rdy=4'b0100 in cycle 0; resp_val=4'b0100 with RAM data in cycle 1; ptr becomes 3.
REQ-033 All 4 requesters hold req_val continuously and resp_rdy=1: grant order is 0,1,2,3,0 in consecutive cycles, and each response routes to the matching resp_val bit.
REQ-034 Requester 1 owns the response with resp_rdy[1]=0 for 3 cycles while requesters 0 and 3 request: no req_rdy asserts, resp_val stays 4'b0010, and ptr holds; after release, requester 3 is granted (ptr=2).
REQ-035 Reset (rst_n=0) asserted during a backpressured response: next cycle resp_val=0 and ptr=0; the first post-reset grant goes to the lowest-index active requester.
REQ-036 With RAM_RD_ARBITER_STATS_EN defined, 70000 handshakes on requester 0 leave grant_cnt[0]=0xFFFF and the other counters at 0.
